// File: rtl/iob_fifo_ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// iob_fifo_ram_ctrl_pkg
// Shared types for the FIFO-over-external-RAM controller.
//   fifoOp_t : per-cycle RAM activity, encoded as {push, read}, used to
//              update the committed-word count in one place.
// ---------------------------------------------------------------------------
package iob_fifo_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_READ = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifoOp_t;

endpackage

// File: rtl/iob_ram_atdp_be.sv
// ---------------------------------------------------------------------------
// iob_ram_atdp_be
// Dual-port RAM model with byte enables and registered read.
//   Port A (clkA_i): enA_i, wstrbA_i, addrA_i, dA_i  -- byte-enable write
//   Port B (clkB_i): enB_i, wstrbB_i, addrB_i, dB_o  -- registered read;
//                    dB_o holds its value while enB_i=0
// Port B has no write-data path here; a non-zero wstrbB_i suppresses the
// read so dB_o holds, matching a write attempt with nothing to write.
// ---------------------------------------------------------------------------
module iob_ram_atdp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                  clkA_i,
  input  logic                  enA_i,
  input  logic [DATA_W/8-1:0]   wstrbA_i,
  input  logic [ADDR_W-1:0]     addrA_i,
  input  logic [DATA_W-1:0]     dA_i,
  input  logic                  clkB_i,
  input  logic                  enB_i,
  input  logic [DATA_W/8-1:0]   wstrbB_i,
  input  logic [ADDR_W-1:0]     addrB_i,
  output logic [DATA_W-1:0]     dB_o
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clkA_i) begin
    if (enA_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrbA_i[b]) mem[addrA_i][b*8 +: 8] <= dA_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clkB_i) begin
    if (enB_i && (wstrbB_i == '0)) dB_o <= mem[addrB_i];
  end

endmodule

// File: rtl/iob_fifo_ram_ctrl.sv
// ---------------------------------------------------------------------------
// iob_fifo_ram_ctrl
// FIFO controller driving an external dual-port RAM. Words are written
// through RAM port A and prefetched through port B; the registered read
// output of port B acts as the FIFO head, so total capacity is the RAM
// depth plus one.
//   clk_i, rst_n_i              : clock, synchronous active-low reset
//   w_valid_i/w_ready_o/w_data_i: write handshake
//   r_valid_o/r_ready_i/r_data_o: read handshake (r_data_o = ext_mem_b_d_i)
//   level_o, empty_o, full_o    : occupancy status
//   ext_mem_a_*                 : RAM write port
//   ext_mem_b_*                 : RAM read port
// ---------------------------------------------------------------------------
module iob_fifo_ram_ctrl
  import iob_fifo_ram_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [DATA_W-1:0]   w_data_i,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  output logic [DATA_W-1:0]   r_data_o,
  output logic [ADDR_W:0]     level_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                ext_mem_a_en_o,
  output logic [DATA_W/8-1:0] ext_mem_a_wstrb_o,
  output logic [ADDR_W-1:0]   ext_mem_a_addr_o,
  output logic [DATA_W-1:0]   ext_mem_a_d_o,
  output logic                ext_mem_b_en_o,
  output logic [DATA_W/8-1:0] ext_mem_b_wstrb_o,
  output logic [ADDR_W-1:0]   ext_mem_b_addr_o,
  input  logic [DATA_W-1:0]   ext_mem_b_d_i
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] wPtr;
  logic [ADDR_W-1:0] rPtr;
  logic [ADDR_W:0]   ramCnt;
  logic              vld_p1;
  logic              push;
  logic              read;
  fifoOp_t           op;

  // ramCnt never exceeds DEPTH, so "ramCnt < DEPTH" is just its MSB clear.
  // Depends on registered state and reset only, never on r_ready_i.
  assign w_ready_o = rst_n_i && !ramCnt[ADDR_W];
  assign push      = w_valid_i && w_ready_o;

  // Only committed words are read, so rPtr never equals a same-cycle wPtr
  // write target.
  assign read = rst_n_i && (ramCnt != '0) && (!vld_p1 || r_ready_i);
  assign op   = fifoOp_t'({push, read});

  assign ext_mem_a_en_o    = push;
  assign ext_mem_a_wstrb_o = {STRB_W{push}};
  assign ext_mem_a_addr_o  = wPtr;
  assign ext_mem_a_d_o     = w_data_i;

  assign ext_mem_b_en_o    = read;
  assign ext_mem_b_wstrb_o = '0;
  assign ext_mem_b_addr_o  = rPtr;

  assign r_valid_o = rst_n_i && vld_p1;
  assign r_data_o  = ext_mem_b_d_i;

  assign level_o = ramCnt + {{ADDR_W{1'b0}}, vld_p1};
  assign empty_o = (level_o == '0);
  assign full_o  = !w_ready_o;

  // Stage p1: RAM read-port output latch; vld_p1 tracks whether it holds
  // the head word.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wPtr   <= '0;
      rPtr   <= '0;
      ramCnt <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (push) wPtr <= wPtr + ADDR_W'(1);
      if (read) rPtr <= rPtr + ADDR_W'(1);
      case (op)
        OP_PUSH: ramCnt <= ramCnt + (ADDR_W + 1)'(1);
        OP_READ: ramCnt <= ramCnt - (ADDR_W + 1)'(1);
        default: ramCnt <= ramCnt;
      endcase
      if (read)           vld_p1 <= 1'b1;
      else if (r_ready_i) vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iob_fifo_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iob_fifo_ram_ctrl
// Controller plus iob_ram_atdp_be, checked against a queue-based FIFO model:
// the model holds every accepted word in order, so the expected head word is
// the queue front and the expected level is the queue size.
// ---------------------------------------------------------------------------
module tb_iob_fifo_ram_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rstN;
  logic              wValid;
  logic              wReady;
  logic [DATA_W-1:0] wData;
  logic              rValid;
  logic              rReady;
  logic [DATA_W-1:0] rData;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              full;
  logic              aEn;
  logic [STRB_W-1:0] aWstrb;
  logic [ADDR_W-1:0] aAddr;
  logic [DATA_W-1:0] aD;
  logic              bEn;
  logic [STRB_W-1:0] bWstrb;
  logic [ADDR_W-1:0] bAddr;
  logic [DATA_W-1:0] bD;

  int checks = 0;
  int errors = 0;
  int pushCnt = 0;
  int popCnt = 0;
  logic [DATA_W-1:0] q[$];

  always #5 clk = ~clk;

  iob_fifo_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i            (clk),
    .rst_n_i          (rstN),
    .w_valid_i        (wValid),
    .w_ready_o        (wReady),
    .w_data_i         (wData),
    .r_valid_o        (rValid),
    .r_ready_i        (rReady),
    .r_data_o         (rData),
    .level_o          (level),
    .empty_o          (empty),
    .full_o           (full),
    .ext_mem_a_en_o   (aEn),
    .ext_mem_a_wstrb_o(aWstrb),
    .ext_mem_a_addr_o (aAddr),
    .ext_mem_a_d_o    (aD),
    .ext_mem_b_en_o   (bEn),
    .ext_mem_b_wstrb_o(bWstrb),
    .ext_mem_b_addr_o (bAddr),
    .ext_mem_b_d_i    (bD)
  );

  iob_ram_atdp_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ram (
    .clkA_i  (clk),
    .enA_i   (aEn),
    .wstrbA_i(aWstrb),
    .addrA_i (aAddr),
    .dA_i    (aD),
    .clkB_i  (clk),
    .enB_i   (bEn),
    .wstrbB_i(bWstrb),
    .addrB_i (bAddr),
    .dB_o    (bD)
  );

  task automatic chkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reset for n edges with busy inputs, then release with idle inputs.
  task automatic doRst(input int n);
    @(negedge clk);
    rstN = 1'b0; wValid = 1'b1; wData = $urandom; rReady = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chkEq("rst_wready", wReady, 0);
    chkEq("rst_rvalid", rValid, 0);
    chkEq("rst_level", level, 0);
    chkEq("rst_a_en", aEn, 0);
    chkEq("rst_a_wstrb", aWstrb, 0);
    chkEq("rst_b_en", bEn, 0);
    q.delete();
    @(negedge clk);
    rstN = 1'b1; wValid = 1'b0; rReady = 1'b0;
    #1;
    chkEq("post_level", level, 0);
    chkEq("post_empty", empty, 1);
    chkEq("post_full", full, 0);
    chkEq("post_rvalid", rValid, 0);
    chkEq("post_wready", wReady, 1);
  endtask

  // One clock cycle: check status against the model, drive inputs, then
  // account for the handshakes that the next rising edge will complete.
  task automatic cycle(input logic wv, input logic [DATA_W-1:0] wd, input logic rr,
                       output logic popped);
    @(negedge clk);
    chkEq("level", level, q.size());
    chkEq("empty", empty, q.size() == 0);
    chkEq("full", full, !wReady);
    if (q.size() < DEPTH) chkEq("wready_room", wReady, 1);
    if (q.size() == DEPTH + 1) chkEq("wready_cap", wReady, 0);
    wValid = wv; wData = wd; rReady = rr;
    #1;
    popped = rValid && rr;
    if (popped) begin
      if (q.size() == 0) chkEq("pop_when_empty", rValid, 0);
      else chkEq("rdata", rData, q.pop_front());
      popCnt++;
    end
    chkEq("a_en", aEn, wv && wReady);
    chkEq("b_wstrb", bWstrb, 0);
    if (wv && wReady) begin
      q.push_back(wd);
      pushCnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic p;
    int   k;

    rstN = 1'b0; wValid = 1'b0; wData = '0; rReady = 1'b0;
    doRst(2);

    // Single word: not visible one edge after the push, visible after two.
    cycle(1'b1, 32'h20, 1'b0, p);
    @(posedge clk); #1;
    chkEq("lat_early_rvalid", rValid, 0);
    cycle(1'b0, $urandom, 1'b0, p);
    @(posedge clk); #1;
    chkEq("lat_rvalid", rValid, 1);
    chkEq("lat_rdata", rData, 32'h20);
    chkEq("lat_level", level, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, $urandom, 1'b0, p);
      @(posedge clk); #1;
      chkEq("hold_rvalid", rValid, 1);
      chkEq("hold_rdata", rData, 32'h20);
    end
    cycle(1'b0, '0, 1'b1, p);
    chkEq("single_popped", p, 1);
    cycle(1'b0, '0, 1'b0, p);

    // Fill to capacity, try one more, then drain in order.
    doRst(1);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 32'h20 + i, 1'b0, p);
    cycle(1'b1, 32'hDEAD, 1'b0, p);
    @(posedge clk); #1;
    chkEq("fill_level", level, DEPTH + 1);
    chkEq("fill_full", full, 1);
    chkEq("fill_wready", wReady, 0);
    popCnt = 0;
    k = 0;
    while ((q.size() > 0) && (k < 40)) begin
      cycle(1'b0, '0, 1'b1, p);
      k++;
    end
    chkEq("drain_left", q.size(), 0);
    chkEq("drain_count", popCnt, DEPTH + 1);
    cycle(1'b0, '0, 1'b0, p);
    @(posedge clk); #1;
    chkEq("drain_empty", empty, 1);

    // Streaming: one push and one pop per cycle once the pipe is primed.
    doRst(1);
    popCnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 32'h100 + i, 1'b1, p);
      if (i >= 2) chkEq("stream_nobubble", p, 1);
    end
    k = 0;
    while ((q.size() > 0) && (k < 10)) begin
      cycle(1'b0, '0, 1'b1, p);
      k++;
    end
    chkEq("stream_count", popCnt, 40);

    // Reset with five words stored discards them all.
    doRst(1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h500 + i, 1'b0, p);
    cycle(1'b0, '0, 1'b0, p);
    @(posedge clk); #1;
    chkEq("pre_rst_level", level, 5);
    doRst(1);
    cycle(1'b1, 32'hAA, 1'b0, p);
    cycle(1'b0, '0, 1'b0, p);
    cycle(1'b0, '0, 1'b1, p);
    chkEq("after_rst_popped", p, 1);
    chkEq("after_rst_empty_model", q.size(), 0);

    // Random traffic against the queue model.
    doRst(1);
    pushCnt = 0;
    popCnt = 0;
    for (int c = 0; (c < 3000) && (pushCnt < 200); c++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), p);
    end
    chkEq("rand_pushed", pushCnt, 200);
    k = 0;
    while ((q.size() > 0) && (k < 40)) begin
      cycle(1'b0, '0, 1'b1, p);
      k++;
    end
    chkEq("rand_popped", popCnt, 200);
    cycle(1'b0, '0, 1'b0, p);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
